// File: rtl/mmio_pkg.sv
// GPIO peripheral register map shared by the top level and the bench.
// Byte offsets inside the 32-byte register window.
package mmio_pkg;

    localparam int WIN_BYTES = 32;
    localparam int WIN_AW    = $clog2(WIN_BYTES);

    localparam logic [WIN_AW-1:0] OFF_LED_DATA  = 5'h00;
    localparam logic [WIN_AW-1:0] OFF_SW_IN     = 5'h04;
    localparam logic [WIN_AW-1:0] OFF_LED_SET   = 5'h08;
    localparam logic [WIN_AW-1:0] OFF_LED_CLR   = 5'h0C;
    localparam logic [WIN_AW-1:0] OFF_LED_TGL   = 5'h10;
    localparam logic [WIN_AW-1:0] OFF_EDGE_STAT = 5'h14;
    localparam logic [WIN_AW-1:0] OFF_IRQ_EN    = 5'h18;
    localparam logic [WIN_AW-1:0] OFF_EDGE_MODE = 5'h1C;

endpackage

// File: rtl/switch_debouncer.sv
// One switch bit: two-flop synchroniser, stability counter, accepted value.
// Ports: clk, reset_n, sw (raw pin) -> deb, rise_pulse, fall_pulse.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw,
    output logic deb,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic s1;
    logic sync;
    logic acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            sync <= 1'b0;
        end else begin
            s1   <= sw;
            sync <= s1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign acc = sync ^ deb;
        end else begin : g_cnt
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;

            // accept on the Nth consecutive cycle of disagreement
            assign acc = (sync ^ deb) && (cnt == LAST);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                end else if (sync == deb || acc) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb <= 1'b0;
        end else if (acc) begin
            deb <= sync;
        end
    end

    // pulses coincide with the edge on which deb changes
    assign rise_pulse = acc & sync;
    assign fall_pulse = acc & ~sync;

endmodule

// File: rtl/mmio_gpio_ctrl.sv
// Memory-mapped GPIO: LED register with set/clr/tgl, debounced switches,
// sticky edge capture and irq. Ports: bus (addr/wdata/we/rdata), leds, switches, irq.
module mmio_gpio_ctrl
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h4000_0000,
    parameter int          N_LEDS          = 10,
    parameter int          N_SW            = 10,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    output logic [31:0]       rdata,
    output logic [N_LEDS-1:0] leds,
    input  logic [N_SW-1:0]   switches,
    output logic              irq
);

    logic [N_SW-1:0]   deb;
    logic [N_SW-1:0]   rise;
    logic [N_SW-1:0]   fall;
    logic [N_SW-1:0]   edge_stat;
    logic [N_SW-1:0]   irq_en;
    logic [N_SW-1:0]   edge_mode;
    logic [N_SW-1:0]   edge_set;
    logic [N_SW-1:0]   w1c_mask;
    logic [N_LEDS-1:0] wled;
    logic [N_SW-1:0]   wsw;
    logic [WIN_AW-1:0] off;
    logic              in_win;
    logic              wr;
    logic              unused_wdata;

    assign in_win = addr[31:WIN_AW] == BASE_ADDR[31:WIN_AW];
    // misaligned offsets match no register, so they read 0 and write nothing
    assign off    = addr[WIN_AW-1:0];
    assign wr     = we & in_win;
    assign wled   = wdata[N_LEDS-1:0];
    assign wsw    = wdata[N_SW-1:0];
    assign unused_wdata = ^wdata;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        switch_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk       (clk),
            .reset_n   (reset_n),
            .sw        (switches[i]),
            .deb       (deb[i]),
            .rise_pulse(rise[i]),
            .fall_pulse(fall[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds <= '0;
        end else if (wr) begin
            unique case (off)
                OFF_LED_DATA: leds <= wled;
                OFF_LED_SET:  leds <= leds | wled;
                OFF_LED_CLR:  leds <= leds & ~wled;
                OFF_LED_TGL:  leds <= leds ^ wled;
                default:      leds <= leds;
            endcase
        end
    end

    assign edge_set = rise | (fall & edge_mode);
    assign w1c_mask = (wr && off == OFF_EDGE_STAT) ? wsw : '0;

    // a new edge overrides a simultaneous W1C of the same bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_stat <= '0;
            irq_en    <= '0;
            edge_mode <= '0;
        end else begin
            edge_stat <= (edge_stat & ~w1c_mask) | edge_set;
            if (wr && off == OFF_IRQ_EN) begin
                irq_en <= wsw;
            end
            if (wr && off == OFF_EDGE_MODE) begin
                edge_mode <= wsw;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (in_win) begin
            unique case (off)
                OFF_LED_DATA:  rdata[N_LEDS-1:0] = leds;
                OFF_SW_IN:     rdata[N_SW-1:0]   = deb;
                OFF_EDGE_STAT: rdata[N_SW-1:0]   = edge_stat;
                OFF_IRQ_EN:    rdata[N_SW-1:0]   = irq_en;
                OFF_EDGE_MODE: rdata[N_SW-1:0]   = edge_mode;
                default:       rdata = '0;
            endcase
        end
    end

    assign irq = |(edge_stat & irq_en);

endmodule

// File: tb/tb_mmio_gpio_ctrl.sv
// Bench for mmio_gpio_ctrl: directed register/debounce/edge cases,
// then random traffic scored against a behavioural model.
module tb_mmio_gpio_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int DB = 4;
    localparam logic [31:0] A_LED  = BASE + 32'h00;
    localparam logic [31:0] A_SW   = BASE + 32'h04;
    localparam logic [31:0] A_SET  = BASE + 32'h08;
    localparam logic [31:0] A_CLR  = BASE + 32'h0C;
    localparam logic [31:0] A_TGL  = BASE + 32'h10;
    localparam logic [31:0] A_STAT = BASE + 32'h14;
    localparam logic [31:0] A_EN   = BASE + 32'h18;
    localparam logic [31:0] A_MODE = BASE + 32'h1C;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [9:0]  leds;
    logic [9:0]  switches;
    logic        irq;

    always #5 clk = ~clk;

    mmio_gpio_ctrl #(
        .BASE_ADDR      (BASE),
        .N_LEDS         (10),
        .N_SW           (10),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .leds    (leds),
        .switches(switches),
        .irq     (irq)
    );

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // behavioural model: a pin value is accepted once the synchronised
    // value has differed from the accepted one for DB consecutive cycles
    logic [9:0] led_m, stat_m, en_m, mode_m, deb_m;
    logic [9:0] p1_m, p2_m, runv_m, m_s, m_set;
    int         run_m[10];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_m = '0; stat_m = '0; en_m = '0; mode_m = '0;
            deb_m = '0; p1_m = '0; p2_m = '0; runv_m = '0;
            for (int i = 0; i < 10; i++) run_m[i] = 0;
        end else begin
            m_s = p2_m;
            p2_m = p1_m;
            p1_m = switches;
            m_set = '0;
            for (int i = 0; i < 10; i++) begin
                if (m_s[i] == runv_m[i]) begin
                    run_m[i]++;
                end else begin
                    runv_m[i] = m_s[i];
                    run_m[i] = 1;
                end
                if (m_s[i] != deb_m[i] && run_m[i] >= DB) begin
                    deb_m[i] = m_s[i];
                    if (m_s[i] || mode_m[i]) m_set[i] = 1'b1;
                end
            end
            if (we && addr[31:5] == BASE[31:5] && addr[1:0] == 2'b00) begin
                case (addr[4:0])
                    5'h00: led_m = wdata[9:0];
                    5'h08: led_m = led_m | wdata[9:0];
                    5'h0C: led_m = led_m & ~wdata[9:0];
                    5'h10: led_m = led_m ^ wdata[9:0];
                    5'h14: stat_m = stat_m & ~wdata[9:0];
                    5'h18: en_m = wdata[9:0];
                    5'h1C: mode_m = wdata[9:0];
                    default: ;
                endcase
            end
            stat_m = stat_m | m_set;
        end
    end

    function automatic logic [31:0] rd_model(logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a[31:5] == BASE[31:5] && a[1:0] == 2'b00) begin
            case (a[4:0])
                5'h00: r = {22'h0, led_m};
                5'h04: r = {22'h0, deb_m};
                5'h14: r = {22'h0, stat_m};
                5'h18: r = {22'h0, en_m};
                5'h1C: r = {22'h0, mode_m};
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    // monitor: compares every queued expectation against the live outputs
    exp_t        mon_e;
    logic [31:0] mon_act;

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            case (mon_e.kind)
                0:       mon_act = rdata;
                1:       mon_act = {22'h0, leds};
                default: mon_act = {31'h0, irq};
            endcase
            n_tests++;
            if (mon_act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h",
                         mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int kind, string name, logic [31:0] exp);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic rd(logic [31:0] a, string name, logic [31:0] exp);
        addr = a;
        push(0, name, exp);
        tick();
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic waitc(int n);
        repeat (n) tick();
    endtask

    logic [31:0] led_offs[4] = '{32'h00, 32'h08, 32'h0C, 32'h10};
    int          budget;
    int          op;

    initial begin
        addr = '0;
        wdata = '0;
        we = 1'b0;
        switches = 10'h3FF;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        push(1, "rst_leds", 32'h0);
        push(2, "rst_irq", 32'h0);
        for (int o = 0; o < 8; o++) rd(BASE + 32'(o * 4), "rst_reg", 32'h0);
        reset_n = 1'b1;
        tick();
        repeat (5) rd(A_SW, "sw_after_rst", 32'h0);
        rd(A_SW, "sw_accept", 32'h3FF);
        switches = 10'h0;
        waitc(8);
        wr(A_STAT, 32'h3FF);
        rd(A_STAT, "stat_clear", 32'h0);

        // LED ops
        wr(A_LED, 32'h0F0);
        wr(A_SET, 32'h003);
        wr(A_CLR, 32'h010);
        wr(A_TGL, 32'h300);
        push(1, "led_ops", 32'h3E3);
        rd(A_LED, "led_rd", 32'h3E3);
        rd(A_SET, "set_rd0", 32'h0);
        rd(A_TGL, "tgl_rd0", 32'h0);

        // debounce: short bounce rejected, held level accepted at 6 cycles
        switches[0] = 1'b1;
        waitc(3);
        switches[0] = 1'b0;
        waitc(8);
        rd(A_SW, "bounce_sw", 32'h0);
        rd(A_STAT, "bounce_stat", 32'h0);
        switches[0] = 1'b1;
        tick();
        repeat (5) rd(A_SW, "deb_early", 32'h0);
        rd(A_SW, "deb_6cyc", 32'h1);
        switches[0] = 1'b0;
        waitc(8);
        wr(A_STAT, 32'h1);

        // edges and irq
        wr(A_EN, 32'h1);
        wr(A_MODE, 32'h0);
        switches[0] = 1'b1;
        waitc(8);
        push(2, "rise_irq", 32'h1);
        rd(A_STAT, "rise_flag", 32'h1);
        wr(A_STAT, 32'h1);
        push(2, "w1c_irq", 32'h0);
        rd(A_STAT, "w1c_flag", 32'h0);
        switches[0] = 1'b0;
        waitc(8);
        rd(A_STAT, "fall_mode0", 32'h0);
        wr(A_MODE, 32'h1);
        switches[0] = 1'b1;
        waitc(8);
        wr(A_STAT, 32'h1);
        switches[0] = 1'b0;
        waitc(8);
        push(2, "fall_irq", 32'h1);
        rd(A_STAT, "fall_mode1", 32'h1);
        wr(A_EN, 32'h0);
        push(2, "mask_irq", 32'h0);
        rd(A_STAT, "mask_keep", 32'h1);
        wr(A_EN, 32'h1);
        wr(A_STAT, 32'h1);

        // W1C in the same cycle as the rise: set wins
        switches[0] = 1'b1;
        tick();
        waitc(4);
        wr(A_STAT, 32'h1);
        push(2, "race_irq", 32'h1);
        rd(A_STAT, "race_flag", 32'h1);
        wr(A_STAT, 32'h1);
        push(2, "race_irq_clr", 32'h0);
        rd(A_STAT, "race_clr", 32'h0);

        // decode
        wr(BASE + 32'h20, 32'hFFFF);
        wr(BASE + 32'h01, 32'hFFFF);
        push(1, "dec_leds", 32'h3E3);
        rd(BASE + 32'h20, "dec_out", 32'h0);
        rd(BASE + 32'h01, "dec_mis", 32'h0);

        // random traffic against the model
        for (int it = 0; it < 400; it++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: wr(BASE + led_offs[$urandom_range(0, 3)], $urandom);
                1: switches[$urandom_range(0, 9)] ^= 1'b1;
                2: begin
                    addr = BASE + 32'($urandom_range(0, 7) * 4);
                    rd(addr, "rand_rd", rd_model(addr));
                end
                3: wr($urandom_range(0, 1) ? A_EN : A_MODE, $urandom);
                4: wr(A_STAT, $urandom);
                default: wr(BASE ^ ($urandom & 32'h0000_01FF), $urandom);
            endcase
            push(1, "rand_leds", {22'h0, led_m});
            push(2, "rand_irq", {31'h0, |(stat_m & en_m)});
            tick();
        end

        budget = 0;
        while (sbq.size() > 0 && budget < 10) begin
            tick();
            budget++;
        end
        if (sbq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
